// File: rtl/bin_to_bcd_serial.sv
// bin_to_bcd_serial
//   Serial binary-to-BCD converter (shift-and-add-3 / double dabble), one
//   input bit per clock. One conversion in flight; valid/ready on both sides.
//
// Ports:
//   clk       : system clock, all state on rising edge
//   reset     : synchronous, active-high reset
//   in_valid  : bin_in holds a value to convert
//   in_ready  : converter can accept a value (state IDLE)
//   bin_in    : unsigned binary operand, BIN_W bits
//   out_valid : bcd_out/overflow hold a completed result (state DONE)
//   out_ready : consumer accepts result
//   bcd_out   : packed BCD result, digit 0 (units) in bits [3:0]
//   overflow  : value >= 10^DIGITS; bcd_out then holds value mod 10^DIGITS
//   busy      : conversion in progress (state SHIFT)
module bin_to_bcd_serial #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_adj;
    logic               ovf;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Carry-free per-digit correction: digits >= 5 get +3 so that the
    // following doubling wraps at 10 instead of 16.
    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit is a lost 10^DIGITS multiple; it is
    // folded into a sticky flag, leaving acc as value mod 10^DIGITS.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_sr <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            bin_sr <= bin_in;
            acc    <= '0;
            ovf    <= 1'b0;
            cnt    <= CNT_W'(BIN_W);
        end else if (busy) begin
            {acc, bin_sr} <= {acc_adj[BCD_W-2:0], bin_sr, 1'b0};
            ovf           <= ovf | acc_adj[BCD_W-1];
            cnt           <= cnt - CNT_W'(1);
        end
    end

    assign bcd_out  = acc;
    assign overflow = ovf;

endmodule
